// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative decryptor.
// Holds the key-length enum, Nr lookup, GF(2^8) arithmetic, the inverse
// S-box (computed as inverse affine followed by field inversion, so no
// 256-entry table is needed) and the inverse ShiftRows/MixColumns layers.
// Block byte 0 is bits [127:120]; byte k sits at row k%4, column k/4.
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_MAX_NR = 14;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2,
    KEY_ILL = 2'd3
  } key_len_e;

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      KEY_256: return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Undo the affine map (rotl 1/3/6 ^ 0x05), then invert as x^254 (0 -> 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] acc;
    b   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq  = b;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [AES_BLK_W-1:0] inv_shift_rows(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = s[127 - 8*(r + 4*c) -: 8];
    return o;
  endfunction

  function automatic logic [AES_BLK_W-1:0] inv_mix_columns(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_dec_round.sv
// One combinational AES inverse round.
// Ports: state_i (128) round input, key_i (128) round key, final_i skips
// InvMixColumns for the last round, state_o (128) round output.
module aes_dec_round
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state_i,
  input  logic [AES_BLK_W-1:0] key_i,
  input  logic                 final_i,
  output logic [AES_BLK_W-1:0] state_o
);

  logic [AES_BLK_W-1:0] sr;
  logic [AES_BLK_W-1:0] sb;
  logic [AES_BLK_W-1:0] ak;

  always_comb begin
    sr = inv_shift_rows(state_i);
    sb = '0;
    for (int i = 0; i < 16; i++)
      sb[8*i +: 8] = inv_sbox(sr[8*i +: 8]);
    ak = sb ^ key_i;
    state_o = final_i ? ak : inv_mix_columns(ak);
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128/192/256 decryptor, UNROLL (1 or 2) inverse rounds per clock.
// Ports: clk_i, reset_n_i (async, active-low); input side in_v_i/in_ready_o
// with key_len_i, ciphertext_i and a 15-slice pre-expanded key_chain_i
// (slice 0 = last encryption round key); output side out_v_o/out_ready_i with
// plaintext_o and err_o (block accepted with illegal key length).
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                in_v_i,
  output logic                                in_ready_o,
  input  logic [1:0]                          key_len_i,
  input  logic [AES_BLK_W-1:0]                ciphertext_i,
  input  logic [(AES_MAX_NR+1)*AES_BLK_W-1:0] key_chain_i,
  output logic                                out_v_o,
  input  logic                                out_ready_i,
  output logic [AES_BLK_W-1:0]                plaintext_o,
  output logic                                err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e                                fsm;
  logic [3:0]                          rnd;
  key_len_e                            klen;
  logic [(AES_MAX_NR+1)*AES_BLK_W-1:0] chain;
  logic [AES_BLK_W-1:0]                st;
  logic [3:0]                          nr;

  logic [AES_BLK_W-1:0] stage [UNROLL+1];
  logic [3:0]           r_idx [UNROLL];
  logic                 fin   [UNROLL];

  assign nr       = nr_of(klen);
  assign stage[0] = st;

  // Round chain; Nr is even and UNROLL divides it, so the final round always
  // lands on the last instance of the chain.
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    assign r_idx[u] = rnd + 4'(u);
    assign fin[u]   = (r_idx[u] == nr);
    aes_dec_round u_round (
      .state_i (stage[u]),
      .key_i   (chain[{r_idx[u], 7'd0} +: AES_BLK_W]),
      .final_i (fin[u]),
      .state_o (stage[u+1])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fsm         <= S_IDLE;
      in_ready_o  <= 1'b1;
      out_v_o     <= 1'b0;
      plaintext_o <= '0;
      err_o       <= 1'b0;
      rnd         <= 4'd0;
      klen        <= KEY_128;
      chain       <= '0;
      st          <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_v_i && in_ready_o) begin
            klen       <= key_len_e'(key_len_i);
            chain      <= key_chain_i;
            st         <= ciphertext_i ^ key_chain_i[AES_BLK_W-1:0];
            rnd        <= 4'd1;
            in_ready_o <= 1'b0;
            if (key_len_i == KEY_ILL) begin
              fsm         <= S_DONE;
              out_v_o     <= 1'b1;
              plaintext_o <= '0;
              err_o       <= 1'b1;
            end else begin
              fsm <= S_RUN;
            end
          end
        end
        S_RUN: begin
          st  <= stage[UNROLL];
          rnd <= rnd + 4'(UNROLL);
          if (fin[UNROLL-1]) begin
            fsm         <= S_DONE;
            out_v_o     <= 1'b1;
            plaintext_o <= stage[UNROLL];
            err_o       <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            fsm        <= S_IDLE;
            out_v_o    <= 1'b0;
            in_ready_o <= 1'b1;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter using the FIPS-197 example vectors.
// Round-key chains are built here by an independent forward key expansion.
module tb_aes_decrypt_iter;

  localparam int UNROLL = 1;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           in_v = 1'b0;
  logic           in_ready;
  logic [1:0]     key_len = 2'd0;
  logic [127:0]   ciphertext = '0;
  logic [1919:0]  key_chain = '0;
  logic           out_v;
  logic           out_ready = 1'b1;
  logic [127:0]   plaintext;
  logic           err;

  logic [1919:0]  k128, k192, k256;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_decrypt_iter #(.UNROLL(UNROLL)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .in_v_i       (in_v),
    .in_ready_o   (in_ready),
    .key_len_i    (key_len),
    .ciphertext_i (ciphertext),
    .key_chain_i  (key_chain),
    .out_v_o      (out_v),
    .out_ready_i  (out_ready),
    .plaintext_o  (plaintext),
    .err_o        (err)
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
  endfunction

  // Key left-aligned in 256 bits; chain slice m = encryption round key Nr-m.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ch;
    int            nr;
    nr = nk + 6;
    rc = 8'h01;
    ch = '0;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int m = 0; m <= nr; m++)
      ch[m*128 +: 128] = {w[4*(nr-m)], w[4*(nr-m)+1], w[4*(nr-m)+2], w[4*(nr-m)+3]};
    return ch;
  endfunction

  task automatic accept(input logic [1:0] kl, input logic [1919:0] ch, input logic [127:0] ct);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    key_len    = kl;
    key_chain  = ch;
    ciphertext = ct;
    in_v       = 1'b1;
    @(posedge clk); #1;
    in_v       = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_v && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_v !== 1'b0) begin n_bad++; $display("FAIL reset_out_v: got %b want 0", out_v); end
    n_cmp++; if (plaintext !== 128'h0) begin n_bad++; $display("FAIL reset_plaintext: got %h want 0", plaintext); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_v !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got ready=%b v=%b want ready=1 v=0", in_ready, out_v);
    end
  endtask

  task automatic test_aes128();
    int lat;
    out_ready = 1'b1;
    accept(2'd0, k128, CT128);
    wait_out(lat);
    n_cmp++; if (lat != 10/UNROLL) begin n_bad++; $display("FAIL aes128_latency: got %0d want %0d", lat, 10/UNROLL); end
    n_cmp++; if (plaintext !== PT) begin n_bad++; $display("FAIL aes128_pt: got %h want %h", plaintext, PT); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL aes128_err: got %b want 0", err); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_v !== 1'b0) begin
      n_bad++; $display("FAIL aes128_drain: got ready=%b v=%b want ready=1 v=0", in_ready, out_v);
    end
  endtask

  task automatic test_aes192();
    int lat;
    accept(2'd1, k192, CT192);
    wait_out(lat);
    n_cmp++; if (lat != 12/UNROLL) begin n_bad++; $display("FAIL aes192_latency: got %0d want %0d", lat, 12/UNROLL); end
    n_cmp++; if (plaintext !== PT) begin n_bad++; $display("FAIL aes192_pt: got %h want %h", plaintext, PT); end
    @(posedge clk); #1;
  endtask

  task automatic test_aes256_input_change();
    int lat;
    accept(2'd2, k256, CT256);
    for (int i = 0; i < 60; i++) key_chain[i*32 +: 32] = $urandom;
    for (int i = 0; i < 4; i++) ciphertext[i*32 +: 32] = $urandom;
    key_len = 2'd0;
    wait_out(lat);
    n_cmp++; if (lat != 14/UNROLL) begin n_bad++; $display("FAIL aes256_latency: got %0d want %0d", lat, 14/UNROLL); end
    n_cmp++; if (plaintext !== PT) begin n_bad++; $display("FAIL aes256_pt: got %h want %h", plaintext, PT); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL aes256_err: got %b want 0", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bit stable;
    out_ready = 1'b0;
    accept(2'd0, k128, CT128);
    // Offers during RUN must be ignored.
    for (int i = 0; i < 3; i++) begin
      key_len = 2'd3; ciphertext = ~CT128; in_v = 1'b1;
      @(posedge clk); #1;
      in_v = 1'b0;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_run_ready: got %b want 0", in_ready); end
    end
    wait_out(lat);
    n_cmp++; if (plaintext !== PT) begin n_bad++; $display("FAIL bp_pt: got %h want %h", plaintext, PT); end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_v = i[0];
      @(posedge clk); #1;
      if (out_v !== 1'b1 || in_ready !== 1'b0 || plaintext !== PT || err !== 1'b0) stable = 1'b0;
    end
    in_v = 1'b0;
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL bp_hold: got unstable v=%b ready=%b pt=%h want held", out_v, in_ready, plaintext); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_v !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: got ready=%b v=%b want ready=1 v=0", in_ready, out_v);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_v !== 1'b0 || in_ready !== 1'b1) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL bp_no_second_capture: got v=%b ready=%b want v=0 ready=1", out_v, in_ready); end
  endtask

  task automatic test_illegal_key();
    int lat;
    accept(2'd3, k128, CT128);
    n_cmp++; if (out_v !== 1'b1) begin n_bad++; $display("FAIL ill_out_v: got %b want 1", out_v); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", err); end
    n_cmp++; if (plaintext !== 128'h0) begin n_bad++; $display("FAIL ill_pt: got %h want 0", plaintext); end
    @(posedge clk); #1;
    accept(2'd0, k128, CT128);
    wait_out(lat);
    n_cmp++; if (plaintext !== PT || err !== 1'b0) begin
      n_bad++; $display("FAIL ill_recover: got pt=%h err=%b want pt=%h err=0", plaintext, err, PT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit quiet;
    accept(2'd2, k256, CT256);
    repeat (4) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_v !== 1'b0 || plaintext !== 128'h0 || err !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got ready=%b v=%b pt=%h err=%b want 1 0 0 0", in_ready, out_v, plaintext, err);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_v !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (!quiet) begin n_bad++; $display("FAIL mid_reset_no_output: got out_v pulse want none"); end
    accept(2'd0, k128, CT128);
    wait_out(lat);
    n_cmp++; if (plaintext !== PT || lat != 10/UNROLL) begin
      n_bad++; $display("FAIL mid_reset_recover: got pt=%h lat=%0d want pt=%h lat=%0d", plaintext, lat, PT, 10/UNROLL);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, c0, c1;
    out_ready = 1'b1;
    accept(2'd0, k128, CT128);
    c0 = cyc;
    wait_out(lat);
    accept(2'd1, k192, CT192);
    c1 = cyc;
    n_cmp++; if (c1 - c0 != 10/UNROLL + 2) begin
      n_bad++; $display("FAIL b2b_period: got %0d want %0d", c1 - c0, 10/UNROLL + 2);
    end
    wait_out(lat);
    n_cmp++; if (plaintext !== PT || lat != 12/UNROLL) begin
      n_bad++; $display("FAIL b2b_second: got pt=%h lat=%0d want pt=%h lat=%0d", plaintext, lat, PT, 12/UNROLL);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    k128 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    k192 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    k256 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256_input_change();
    test_backpressure();
    test_illegal_key();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
